// File: rtl/vote_round_ctrl.sv
// -----------------------------------------------------------------------------
// vote_round_ctrl
//
// Runs the voting rounds for the 3-input majority voter (y = AB | AC | BC).
// A start pulse opens a round. The block then collects one vote from each of
// the three judges and closes the round on full completion or on timeout.
// It holds the majority result under a valid/ack handshake and keeps
// saturating pass/fail tallies.
//
// Optional feature (compile-time macro VOTE_EARLY_EN):
//   When defined, a round also closes as soon as two latched votes agree.
//   When undefined, a round closes only on full completion or timeout.
//
// Parameters:
//   TIMEOUT_CYC  COLLECT cycles allowed before a forced decision (>= 2)
//   CNT_W        width of the pass/fail tally counters
//
// Ports:
//   clk           system clock, rising edge
//   resetn        synchronous active-low reset
//   start         begin a round (honoured only in IDLE)
//   vote_valid    per-judge vote strobe, bit i = judge i
//   vote_val      per-judge vote value (1 = approve), qualified by vote_valid
//   ack           consumer accepts result (honoured only in RESULT)
//   busy          high in COLLECT and RESULT
//   voted         judges whose vote is latched this round
//   result_valid  high in RESULT
//   result        majority of latched votes (missing votes count as 0)
//   timeout       round closed by timeout, valid with result_valid
//   pass_cnt      rounds with result = 1, saturating
//   fail_cnt      rounds with result = 0, saturating
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; round registers held cleared
// S_COLLECT| latching first vote of each judge, timeout counter running
// S_RESULT | result/timeout/voted frozen, waiting for ack
// -----------------------------------------------------------------------------
module vote_round_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       vote_valid,
  input  logic [2:0]       vote_val,
  input  logic             ack,
  output logic             busy,
  output logic [2:0]       voted,
  output logic             result_valid,
  output logic             result,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int               TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic               busy_q,    busy_d;
  logic               rv_q,      rv_d;
  logic [2:0]         voted_q,   voted_d;
  logic [2:0]         votes_q,   votes_d;
  logic               result_q,  result_d;
  logic               timeout_q, timeout_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   pass_q,    pass_d;
  logic [CNT_W-1:0]   fail_q,    fail_d;

  // The vote picture as it will stand after this edge. Only the first strobe
  // of each judge is accepted, so the vote of a judge that already voted is
  // kept.
  logic [2:0] new_mask;
  logic [2:0] voted_nx;
  logic [2:0] votes_nx;
  logic [2:0] eff_votes;
  logic       majority;
  logic       complete;
  logic       close_now;
  logic       tmo_hit;

  assign new_mask  = vote_valid & ~voted_q;
  assign voted_nx  = voted_q | new_mask;
  assign votes_nx  = (votes_q & ~new_mask) | (vote_val & new_mask);
  // An unvoted judge counts as a 0 vote.
  assign eff_votes = votes_nx & voted_nx;
  assign majority  = (eff_votes[0] & eff_votes[1]) |
                     (eff_votes[0] & eff_votes[2]) |
                     (eff_votes[1] & eff_votes[2]);
  assign complete  = (voted_nx == 3'b111);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

`ifdef VOTE_EARLY_EN
  // Two latched votes that agree already fix the outcome. The majority of
  // the effective votes equals the agreed value in every such case.
  logic agree;
  assign agree = (voted_nx[0] & voted_nx[1] & ~(eff_votes[0] ^ eff_votes[1])) |
                 (voted_nx[0] & voted_nx[2] & ~(eff_votes[0] ^ eff_votes[2])) |
                 (voted_nx[1] & voted_nx[2] & ~(eff_votes[1] ^ eff_votes[2]));
  assign close_now = complete | agree;
`else
  assign close_now = complete;
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    rv_d      = rv_q;
    voted_d   = voted_q;
    votes_d   = votes_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    tmo_cnt_d = tmo_cnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;

    case (state_q)
      S_IDLE: begin
        voted_d   = '0;
        votes_d   = '0;
        tmo_cnt_d = '0;
        result_d  = 1'b0;
        timeout_d = 1'b0;
        if (start) begin
          state_d = S_COLLECT;
          busy_d  = 1'b1;
        end
      end

      S_COLLECT: begin
        voted_d = voted_nx;
        votes_d = votes_nx;
        // Completion takes priority over a timeout on the same edge.
        if (close_now || tmo_hit) begin
          state_d   = S_RESULT;
          rv_d      = 1'b1;
          result_d  = majority;
          timeout_d = ~close_now;
          if (majority) begin
            if (pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_RESULT: begin
        if (ack) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          rv_d      = 1'b0;
          voted_d   = '0;
          votes_d   = '0;
          tmo_cnt_d = '0;
          result_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        rv_d      = 1'b0;
        voted_d   = '0;
        votes_d   = '0;
        tmo_cnt_d = '0;
        result_d  = 1'b0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      voted_q   <= '0;
      votes_q   <= '0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      voted_q   <= voted_d;
      votes_q   <= votes_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      tmo_cnt_q <= tmo_cnt_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign voted        = voted_q;
  assign result       = result_q;
  assign timeout      = timeout_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Bench for vote_round_ctrl. Stimulus pushes the expected round outcome into
// a queue. A monitor pops one entry on each rising result_valid and compares
// it against the DUT outputs and the cycle on which the result appeared.
module tb_vote_round_ctrl;
  localparam int TMO = 16;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    vote_valid = '0;
  logic [2:0]    vote_val = '0;
  logic          ack = 1'b0;
  logic          busy;
  logic [2:0]    voted;
  logic          result_valid;
  logic          result;
  logic          timeout;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;

  vote_round_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vote_valid(vote_valid),
    .vote_val(vote_val), .ack(ack), .busy(busy), .voted(voted),
    .result_valid(result_valid), .result(result), .timeout(timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          res;
    logic          tmo;
    logic [2:0]    vmask;
    logic [CW-1:0] pc;
    logic [CW-1:0] fc;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_pass  = 0;
  int   m_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Saturating tally model, max value for CW bits.
  task automatic expect_round(input logic res, input logic tmo, input logic [2:0] vm, input int at);
    exp_t e;
    if (res) begin if (m_pass < 3) m_pass++; end
    else     begin if (m_fail < 3) m_fail++; end
    e.res = res; e.tmo = tmo; e.vmask = vm;
    e.pc = CW'(m_pass); e.fc = CW'(m_fail); e.at = at;
    sb.push_back(e);
  endtask

  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_cycle", cyc, e.at);
        chk("result", result, e.res);
        chk("timeout", timeout, e.tmo);
        chk("voted", voted, e.vmask);
        chk("pass_cnt", pass_cnt, e.pc);
        chk("fail_cnt", fail_cnt, e.fc);
        chk("busy_in_result", busy, 1);
      end
    end
    rv_prev = result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vote(input logic [2:0] vv, input logic [2:0] val);
    vote_valid = vv;
    vote_val   = val;
    tick();
    vote_valid = '0;
    vote_val   = '0;
  endtask

  task automatic wait_rv_and_ack();
    for (int i = 0; i < 40 && !result_valid; i++) tick();
    chk("rv_wait", result_valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_busy", busy, 0);
    chk("ack_rv", result_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset, then idle with vote strobes ignored.
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_voted", voted, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    vote(3'b111, 3'b111);
    chk("idle_voted", voted, 0);
    chk("idle_busy", busy, 0);

    // Full round in one cycle: votes 0,1,1 -> 1.
    do_start();
    chk("collect_busy", busy, 1);
    expect_round(1'b1, 1'b0, 3'b111, cyc + 1);
    vote(3'b111, 3'b110);
    wait_rv_and_ack();

    // Staggered votes with a duplicate strobe from judge 0.
    do_start();
    vote(3'b001, 3'b000);
    vote(3'b001, 3'b001);
    chk("dup_voted", voted, 3'b001);
    vote(3'b010, 3'b000);
    expect_round(1'b0, 1'b0, 3'b111, cyc + 1);
    vote(3'b100, 3'b100);
    wait_rv_and_ack();

    // Timeout with only judge 2 voting 1.
    do_start();
    c0 = cyc;
    expect_round(1'b0, 1'b1, 3'b100, c0 + TMO);
    vote(3'b100, 3'b100);
    wait_rv_and_ack();

    // Third vote lands on the final COLLECT cycle: completion wins.
    do_start();
    c0 = cyc;
    vote(3'b011, 3'b010);
    while (cyc < c0 + TMO - 1) tick();
    chk("last_cycle_rv", result_valid, 0);
    expect_round(1'b1, 1'b0, 3'b111, cyc + 1);
    vote(3'b100, 3'b100);
    wait_rv_and_ack();

    // Judges 0 and 1 agree on 1 in one cycle.
    do_start();
`ifdef VOTE_EARLY_EN
    expect_round(1'b1, 1'b0, 3'b011, cyc + 1);
    vote(3'b011, 3'b011);
`else
    vote(3'b011, 3'b011);
    chk("no_early_rv", result_valid, 0);
    chk("no_early_busy", busy, 1);
    chk("no_early_voted", voted, 3'b011);
    expect_round(1'b1, 1'b0, 3'b111, cyc + 1);
    vote(3'b100, 3'b000);
`endif
    wait_rv_and_ack();

    // Two more passing rounds: pass tally saturates at 3.
    for (int r = 0; r < 2; r++) begin
      do_start();
      expect_round(1'b1, 1'b0, 3'b111, cyc + 1);
      vote(3'b111, 3'b111);
      wait_rv_and_ack();
    end
    chk("sat_pass", pass_cnt, 3);
    chk("sat_fail", fail_cnt, 2);

    // Reset in the middle of a round.
    do_start();
    vote(3'b001, 3'b001);
    chk("mid_voted", voted, 3'b001);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_voted", voted, 0);
    chk("mrst_rv", result_valid, 0);
    chk("mrst_pass", pass_cnt, 0);
    chk("mrst_fail", fail_cnt, 0);
    tick(); tick();
    chk("mrst_idle_busy", busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
